anneal_run_sequencer: RTL and testbench
=======================================

Name: anneal_run_sequencer

Overview:
- Sequences the annealing core through its INIT, LOAD, RUN/anneal, SAMPLE and RERUN phases.
- Driven by the SPI control-register outputs (RESET/INIT/LOAD/RUN/RERUN levels, run interval, run/rerun counts, anneal schedule).
- Produces the handshakes to the init/load/sample datapath and the system status bits that are read back over SPI.

Parameters:
- PRESCALE_DIV, 1000: clock cycles per run_time_interval unit. Must be ≥1.
- LOAD_TIMEOUT, 65535: max cycles waiting for load_done before error.
- SAMPLE_TIMEOUT, 4095: max cycles in SAMPLE. Used only with SEQ_WATCHDOG_EN.

Ports:
- i_clk in 1: system clock.
- i_rst in 1: asynchronous reset, active-high.
- ctrl_reset, ctrl_init, ctrl_load, ctrl_run, ctrl_rerun in 1 each: control-register levels.
- run_time_interval in 8: interval units per anneal step; 0 treated as 1.
- total_run_count in 8: runs per RUN command; 0 treated as 1.
- total_rerun_count in 8: maximum reruns allowed after a run.
- anneal_sch in 128: 16 schedule bytes; step 0 = [127:120], step 15 = [7:0].
- init_start out 1: one-cycle pulse to the init engine.
- init_done in 1: init complete, single-cycle pulse.
- load_start out 1: one-cycle pulse to the loader.
- load_done in 1: load complete, single-cycle pulse.
- anneal_en out 1: high during ANNEAL.
- anneal_step out 8: current schedule byte.
- sample_req out 1: sample request.
- sample_ack in 1: sample accepted.
- fifo_full in 1: sample FIFO full.
- run_idx out 8: current run index.
- rerun_idx out 8: reruns performed.
- stat_running out 1, stat_sampling out 1, stat_loading_done out 1, stat_error out 1: status bits.

Behaviour:
- **Reset (i_rst)**: all outputs 0, state IDLE, snapshots 0, edge-detect history 0.
- **Edge detection**: ctrl_init/load/run/rerun act on the registered 0→1 edge only.
  - Edges in states that do not accept them are dropped, never queued.
- **Edge priority**: when several edges occur in the same cycle: init > load > run > rerun.
- **ctrl_reset level**:
  - While high, forces IDLE synchronously.
  - Clears all status bits, indices and counters.
  - Has priority over every edge.
- **States**: IDLE, INIT, READY, LOAD, ANNEAL, SAMPLE, DONE, ERR.
- **IDLE**: init edge → INIT, with init_start pulsed in the transition cycle.
- **INIT**: init_done → READY. All other edges are ignored.
- **READY**:
  - Load edge → LOAD: load_start pulsed, timeout counter cleared, stat_loading_done cleared.
  - Run edge with stat_loading_done=1 → ANNEAL.
  - Run edge with stat_loading_done=0 → ERR.
  - Init edge → INIT.
- **LOAD**:
  - load_done → READY and stat_loading_done=1.
  - Counter reaching LOAD_TIMEOUT with no load_done → ERR.
  - load_done on the same cycle as the timeout wins.
- **ANNEAL entry from READY/DONE via run edge**:
  - Snapshot run_time_interval, total_run_count, total_rerun_count and anneal_sch.
  - run_idx=0; rerun_idx=0 on run edge.
  - Step k=0, prescaler=0, interval counter=0.
- **ANNEAL**:
  - anneal_en=1, stat_running=1, anneal_step = snapshot byte k.
  - Each step lasts interval×PRESCALE_DIV cycles.
  - After step 15 expires → SAMPLE. anneal_en drops in the same cycle.
  - Anneal length per run = 16×max(interval,1)×PRESCALE_DIV cycles.
- **SAMPLE**:
  - stat_sampling=1, stat_running stays 1.
  - sample_req = !fifo_full; it deasserts while fifo_full=1.
  - A handshake completes when sample_req && sample_ack. An ack without req is ignored.
  - On completion:
    - If run_idx+1 < max(total_run_count,1): run_idx++, → ANNEAL at step 0.
    - Otherwise → DONE.
- **DONE**:
  - stat_running=0; run_idx holds its last value.
  - Rerun edge with rerun_idx < total_rerun_count: rerun_idx++, run_idx=0, → ANNEAL using the existing snapshot (no reload).
  - Rerun edge with rerun_idx == total_rerun_count → ERR.
  - Run edge → fresh run (new snapshot, rerun_idx=0).
  - Load edge → LOAD.
- **ERR**:
  - stat_error=1; all handshake outputs and anneal_en are 0.
  - Exits only via ctrl_reset or i_rst.
- **Snapshot isolation**: SPI writes during ANNEAL/SAMPLE do not alter the active run.
- **Counter widths**: prescaler ceil(log2(PRESCALE_DIV)); interval 8b; step 4b; counters are compared before increment and never wrap.

Optional Feature:
- Macro: SEQ_WATCHDOG_EN.
- Defined: a SAMPLE-state cycle counter (including fifo_full stall) that reaches SAMPLE_TIMEOUT without a completed handshake → ERR.
- Undefined: SAMPLE waits indefinitely; the counter logic and SAMPLE_TIMEOUT are unused.

Test Plan:
- **Init/load/run**: PRESCALE_DIV=4, interval=2, runs=1, anneal_sch=0x00..0F. Sequence: init edge, init_done 3 cycles later, load edge, load_done, run edge, ack on first req → anneal_step steps 0x00..0x0F, 8 cycles each; sample_req after 128 anneal cycles; DONE, run_idx=0, stat_loading_done=1.
- **Multi-run + backpressure**: runs=3; fifo_full high 10 cycles at the second SAMPLE → sample_req low during the stall; 3 handshakes; run_idx ends at 2; stat_running falls after the third ack.
- **Rerun limit**: reruns=1 → first rerun edge re-anneals with the same schedule and rerun_idx=1; second rerun edge → ERR, stat_error=1; ctrl_reset pulse → IDLE with all status 0.
- **Errors**: run edge before any load → ERR. Separately, load with no load_done for LOAD_TIMEOUT cycles → ERR on exactly cycle LOAD_TIMEOUT.
- **Snapshot isolation and simultaneous edges**: change interval to 5 and anneal_sch mid-ANNEAL → current run unchanged. Init and load edges in the same cycle from READY → INIT taken, load dropped.
- **Watchdog**: with SEQ_WATCHDOG_EN and fifo_full held high → ERR after SAMPLE_TIMEOUT cycles; without the macro → state stays SAMPLE indefinitely.

Source files
------------

// File: rtl/anneal_run_sequencer.sv
// anneal_run_sequencer: steps the annealing core through INIT, LOAD, ANNEAL,
// SAMPLE and RERUN phases from SPI control-register levels.
// Optional feature macro: SEQ_WATCHDOG_EN (SAMPLE-state timeout into ERR).
module anneal_run_sequencer #(
    parameter int unsigned PRESCALE_DIV   = 1000,
    parameter int unsigned LOAD_TIMEOUT   = 65535,
    parameter int unsigned SAMPLE_TIMEOUT = 4095
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         ctrl_reset,
    input  logic         ctrl_init,
    input  logic         ctrl_load,
    input  logic         ctrl_run,
    input  logic         ctrl_rerun,
    input  logic [7:0]   run_time_interval,
    input  logic [7:0]   total_run_count,
    input  logic [7:0]   total_rerun_count,
    input  logic [127:0] anneal_sch,
    output logic         init_start,
    input  logic         init_done,
    output logic         load_start,
    input  logic         load_done,
    output logic         anneal_en,
    output logic [7:0]   anneal_step,
    output logic         sample_req,
    input  logic         sample_ack,
    input  logic         fifo_full,
    output logic [7:0]   run_idx,
    output logic [7:0]   rerun_idx,
    output logic         stat_running,
    output logic         stat_sampling,
    output logic         stat_loading_done,
    output logic         stat_error
);

    localparam int unsigned PRE_W   = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam int unsigned TMO_MAX = (LOAD_TIMEOUT > SAMPLE_TIMEOUT) ? LOAD_TIMEOUT : SAMPLE_TIMEOUT;
    localparam int unsigned TMO_W   = ($clog2(TMO_MAX + 1) > 1) ? $clog2(TMO_MAX + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_READY, S_LOAD, S_ANNEAL, S_SAMPLE, S_DONE, S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          hist_q;
    logic [3:0]          k_q, k_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [7:0]          ivl_q, ivl_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [7:0]          run_idx_d, rerun_idx_d;
    logic                loaded_d;
    logic [7:0]          ivl_snap_q, ivl_snap_d;
    logic [7:0]          runs_snap_q, runs_snap_d;
    logic [7:0]          rerun_snap_q, rerun_snap_d;
    logic [15:0][7:0]    sch_snap_q, sch_snap_d;
    logic                init_start_d, load_start_d;
    logic                anneal_en_d, sample_req_d;
    logic [7:0]          anneal_step_d;
    logic                stat_running_d, stat_sampling_d, stat_error_d;
    logic                init_edge, load_edge, run_edge, rerun_edge;
    logic                fresh_run, restart_anneal;

    assign init_edge  = ctrl_init  & ~hist_q[0];
    assign load_edge  = ctrl_load  & ~hist_q[1];
    assign run_edge   = ctrl_run   & ~hist_q[2];
    assign rerun_edge = ctrl_rerun & ~hist_q[3];

    // State, counters, indices, snapshots and control-level history
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q           <= S_IDLE;
            hist_q            <= '0;
            k_q               <= '0;
            pre_q             <= '0;
            ivl_q             <= '0;
            tmo_q             <= '0;
            run_idx           <= '0;
            rerun_idx         <= '0;
            stat_loading_done <= 1'b0;
            ivl_snap_q        <= '0;
            runs_snap_q       <= '0;
            rerun_snap_q      <= '0;
            sch_snap_q        <= '0;
        end else begin
            state_q           <= state_d;
            hist_q            <= {ctrl_rerun, ctrl_run, ctrl_load, ctrl_init};
            k_q               <= k_d;
            pre_q             <= pre_d;
            ivl_q             <= ivl_d;
            tmo_q             <= tmo_d;
            run_idx           <= run_idx_d;
            rerun_idx         <= rerun_idx_d;
            stat_loading_done <= loaded_d;
            ivl_snap_q        <= ivl_snap_d;
            runs_snap_q       <= runs_snap_d;
            rerun_snap_q      <= rerun_snap_d;
            sch_snap_q        <= sch_snap_d;
        end
    end

    // Next-state, counter and snapshot update
    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        pre_d          = pre_q;
        ivl_d          = ivl_q;
        tmo_d          = tmo_q;
        run_idx_d      = run_idx;
        rerun_idx_d    = rerun_idx;
        loaded_d       = stat_loading_done;
        ivl_snap_d     = ivl_snap_q;
        runs_snap_d    = runs_snap_q;
        rerun_snap_d   = rerun_snap_q;
        sch_snap_d     = sch_snap_q;
        init_start_d   = 1'b0;
        load_start_d   = 1'b0;
        fresh_run      = 1'b0;
        restart_anneal = 1'b0;

        if (ctrl_reset) begin
            state_d     = S_IDLE;
            k_d         = '0;
            pre_d       = '0;
            ivl_d       = '0;
            tmo_d       = '0;
            run_idx_d   = '0;
            rerun_idx_d = '0;
            loaded_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (init_edge) begin
                        state_d      = S_INIT;
                        init_start_d = 1'b1;
                    end
                end
                S_INIT: begin
                    if (init_done) state_d = S_READY;
                end
                S_READY: begin
                    if (init_edge) begin
                        state_d      = S_INIT;
                        init_start_d = 1'b1;
                    end else if (load_edge) begin
                        state_d      = S_LOAD;
                        load_start_d = 1'b1;
                        tmo_d        = '0;
                        loaded_d     = 1'b0;
                    end else if (run_edge) begin
                        if (stat_loading_done) fresh_run = 1'b1;
                        else                   state_d   = S_ERR;
                    end
                end
                S_LOAD: begin
                    if (load_done) begin
                        state_d  = S_READY;
                        loaded_d = 1'b1;
                    end else if (tmo_q == TMO_W'(LOAD_TIMEOUT - 1)) begin
                        state_d = S_ERR;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                S_ANNEAL: begin
                    if (pre_q == PRE_W'(PRESCALE_DIV - 1)) begin
                        pre_d = '0;
                        if (ivl_q == ivl_snap_q - 8'd1) begin
                            ivl_d = '0;
                            if (k_q == 4'd15) begin
                                state_d = S_SAMPLE;
                                tmo_d   = '0;
                            end else begin
                                k_d = k_q + 4'd1;
                            end
                        end else begin
                            ivl_d = ivl_q + 8'd1;
                        end
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
                S_SAMPLE: begin
                    if (sample_req && sample_ack) begin
                        if ((9'(run_idx) + 9'd1) < 9'(runs_snap_q)) begin
                            run_idx_d      = run_idx + 8'd1;
                            restart_anneal = 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
`ifdef SEQ_WATCHDOG_EN
                    end else if (tmo_q == TMO_W'(SAMPLE_TIMEOUT - 1)) begin
                        state_d = S_ERR;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
`endif
                    end
                end
                S_DONE: begin
                    if (load_edge) begin
                        state_d      = S_LOAD;
                        load_start_d = 1'b1;
                        tmo_d        = '0;
                        loaded_d     = 1'b0;
                    end else if (run_edge) begin
                        fresh_run = 1'b1;
                    end else if (rerun_edge) begin
                        if (rerun_idx < rerun_snap_q) begin
                            rerun_idx_d    = rerun_idx + 8'd1;
                            run_idx_d      = '0;
                            restart_anneal = 1'b1;
                        end else begin
                            state_d = S_ERR;
                        end
                    end
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // A run edge captures a new snapshot; zero-valued interval/run count act as 1
        if (fresh_run) begin
            ivl_snap_d     = (run_time_interval == 8'd0) ? 8'd1 : run_time_interval;
            runs_snap_d    = (total_run_count == 8'd0) ? 8'd1 : total_run_count;
            rerun_snap_d   = total_rerun_count;
            sch_snap_d     = anneal_sch;
            run_idx_d      = '0;
            rerun_idx_d    = '0;
            restart_anneal = 1'b1;
        end

        if (restart_anneal) begin
            state_d = S_ANNEAL;
            k_d     = '0;
            pre_d   = '0;
            ivl_d   = '0;
        end
    end

    // Output decode from the upcoming state so registered outputs track it
    always_comb begin
        anneal_en_d     = (state_d == S_ANNEAL);
        anneal_step_d   = (state_d == S_ANNEAL) ? sch_snap_d[4'd15 - k_d] : 8'd0;
        sample_req_d    = (state_d == S_SAMPLE) && !fifo_full;
        stat_running_d  = (state_d == S_ANNEAL) || (state_d == S_SAMPLE);
        stat_sampling_d = (state_d == S_SAMPLE);
        stat_error_d    = (state_d == S_ERR);
    end

    // Output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            init_start    <= 1'b0;
            load_start    <= 1'b0;
            anneal_en     <= 1'b0;
            anneal_step   <= '0;
            sample_req    <= 1'b0;
            stat_running  <= 1'b0;
            stat_sampling <= 1'b0;
            stat_error    <= 1'b0;
        end else begin
            init_start    <= init_start_d;
            load_start    <= load_start_d;
            anneal_en     <= anneal_en_d;
            anneal_step   <= anneal_step_d;
            sample_req    <= sample_req_d;
            stat_running  <= stat_running_d;
            stat_sampling <= stat_sampling_d;
            stat_error    <= stat_error_d;
        end
    end

endmodule

// File: tb/tb_anneal_run_sequencer.sv
// Testbench for anneal_run_sequencer: directed phases plus randomized runs
// checked against a cycle-count model of the anneal/sample timing.
module tb_anneal_run_sequencer;

    localparam int PD = 4;
    localparam int LT = 20;
    localparam int ST = 40;
`ifdef SEQ_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         ctrl_reset, ctrl_init, ctrl_load, ctrl_run, ctrl_rerun;
    logic [7:0]   run_time_interval, total_run_count, total_rerun_count;
    logic [127:0] anneal_sch;
    logic         init_start, init_done, load_start, load_done;
    logic         anneal_en, sample_req, sample_ack, fifo_full;
    logic [7:0]   anneal_step, run_idx, rerun_idx;
    logic         stat_running, stat_sampling, stat_loading_done, stat_error;

    anneal_run_sequencer #(
        .PRESCALE_DIV  (PD),
        .LOAD_TIMEOUT  (LT),
        .SAMPLE_TIMEOUT(ST)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .ctrl_reset       (ctrl_reset),
        .ctrl_init        (ctrl_init),
        .ctrl_load        (ctrl_load),
        .ctrl_run         (ctrl_run),
        .ctrl_rerun       (ctrl_rerun),
        .run_time_interval(run_time_interval),
        .total_run_count  (total_run_count),
        .total_rerun_count(total_rerun_count),
        .anneal_sch       (anneal_sch),
        .init_start       (init_start),
        .init_done        (init_done),
        .load_start       (load_start),
        .load_done        (load_done),
        .anneal_en        (anneal_en),
        .anneal_step      (anneal_step),
        .sample_req       (sample_req),
        .sample_ack       (sample_ack),
        .fifo_full        (fifo_full),
        .run_idx          (run_idx),
        .rerun_idx        (rerun_idx),
        .stat_running     (stat_running),
        .stat_sampling    (stat_sampling),
        .stat_loading_done(stat_loading_done),
        .stat_error       (stat_error)
    );

    always #5 i_clk = ~i_clk;

    int passed = 0;
    int total  = 0;

    // Reference snapshot of the active run
    int           m_iv, m_runs, m_reruns, m_rerun_idx;
    logic [127:0] m_sch;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic do_init();
        ctrl_init = 1'b1;
        tick();
        chk("init_start_pulse", init_start, 1);
        ctrl_init = 1'b0;
        tick();
        chk("init_start_drop", init_start, 0);
        tick(2);
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
    endtask

    task automatic do_load();
        ctrl_load = 1'b1;
        tick();
        chk("load_start_pulse", load_start, 1);
        chk("loaded_cleared", stat_loading_done, 0);
        ctrl_load = 1'b0;
        tick();
        chk("load_start_drop", load_start, 0);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        chk("loaded_set", stat_loading_done, 1);
    endtask

    task automatic pulse_reset();
        ctrl_reset = 1'b1;
        tick();
        ctrl_reset = 1'b0;
        chk("creset_error", stat_error, 0);
        chk("creset_running", stat_running, 0);
        chk("creset_sampling", stat_sampling, 0);
        chk("creset_loaded", stat_loading_done, 0);
        chk("creset_run_idx", run_idx, 0);
        chk("creset_rerun_idx", rerun_idx, 0);
        chk("creset_anneal_en", anneal_en, 0);
        m_rerun_idx = 0;
    endtask

    task automatic start_fresh();
        m_iv        = (run_time_interval == 0) ? 1 : int'(run_time_interval);
        m_runs      = (total_run_count == 0) ? 1 : int'(total_run_count);
        m_reruns    = int'(total_rerun_count);
        m_sch       = anneal_sch;
        m_rerun_idx = 0;
        ctrl_run = 1'b1;
        tick();
        ctrl_run = 1'b0;
    endtask

    // Entered at the first ANNEAL cycle; returns at the first SAMPLE cycle
    task automatic anneal_phase(input int run, input bit hold_full);
        int per;
        int len;
        logic [7:0] b;
        per = m_iv * PD;
        len = 16 * per;
        chk("run_idx", run_idx, run);
        chk("rerun_idx", rerun_idx, m_rerun_idx);
        chk("running_anneal", stat_running, 1);
        for (int c = 0; c < len; c++) begin
            b = m_sch[127 - 8 * (c / per) -: 8];
            chk("anneal_en", anneal_en, 1);
            chk("anneal_step", anneal_step, b);
            if (c == len / 2) begin
                run_time_interval = 8'd5;
                total_run_count   = 8'($urandom_range(5, 0));
                anneal_sch        = {$urandom, $urandom, $urandom, $urandom};
            end
            if (hold_full && c == len - 1) fifo_full = 1'b1;
            tick();
        end
        chk("anneal_en_drop", anneal_en, 0);
        chk("sampling_on", stat_sampling, 1);
        chk("running_sample", stat_running, 1);
    endtask

    // Entered at the first SAMPLE cycle; returns one cycle after the accepting ack
    task automatic sample_phase(input int stall, input int delay);
        chk("req_on_entry", sample_req, 1);
        if (stall > 0) begin
            fifo_full = 1'b1;
            tick();
            for (int s = 0; s < stall; s++) begin
                chk("req_stall", sample_req, 0);
                sample_ack = (s == 1);
                tick();
            end
            fifo_full  = 1'b0;
            sample_ack = 1'b0;
            tick();
            chk("req_resume", sample_req, 1);
            chk("sampling_after_stray_ack", stat_sampling, 1);
        end
        for (int d = 0; d < delay; d++) begin
            chk("req_wait", sample_req, 1);
            tick();
        end
        sample_ack = 1'b1;
        tick();
        sample_ack = 1'b0;
    endtask

    task automatic run_all(input int stall_run, input int stall_len);
        for (int r = 0; r < m_runs; r++) begin
            anneal_phase(r, 1'b0);
            sample_phase((r == stall_run) ? stall_len : 0, int'($urandom_range(2, 0)));
        end
        chk("done_running", stat_running, 0);
        chk("done_sampling", stat_sampling, 0);
        chk("done_req", sample_req, 0);
        chk("done_anneal_en", anneal_en, 0);
        chk("done_run_idx", run_idx, m_runs - 1);
    endtask

    // Returns 1 when the rerun was accepted and its runs completed
    task automatic do_rerun(output bit ok);
        ctrl_rerun = 1'b1;
        tick();
        ctrl_rerun = 1'b0;
        if (m_rerun_idx < m_reruns) begin
            m_rerun_idx++;
            run_all(-1, 0);
            ok = 1'b1;
        end else begin
            chk("rerun_limit_err", stat_error, 1);
            chk("err_anneal_en", anneal_en, 0);
            chk("err_running", stat_running, 0);
            chk("err_req", sample_req, 0);
            ok = 1'b0;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "time limit reached");
    end

    initial begin
        bit ok;
        bit exp_err;
        i_rst = 1'b1;
        {ctrl_reset, ctrl_init, ctrl_load, ctrl_run, ctrl_rerun} = '0;
        {init_done, load_done, sample_ack, fifo_full} = '0;
        run_time_interval = 8'd2;
        total_run_count   = 8'd1;
        total_rerun_count = 8'd1;
        anneal_sch        = 128'h000102030405060708090A0B0C0D0E0F;
        m_rerun_idx       = 0;
        tick(3);
        chk("rst_init_start", init_start, 0);
        chk("rst_load_start", load_start, 0);
        chk("rst_anneal_en", anneal_en, 0);
        chk("rst_anneal_step", anneal_step, 0);
        chk("rst_sample_req", sample_req, 0);
        chk("rst_run_idx", run_idx, 0);
        chk("rst_rerun_idx", rerun_idx, 0);
        chk("rst_status", {stat_running, stat_sampling, stat_loading_done, stat_error}, 0);
        i_rst = 1'b0;
        tick();

        // Basic init/load/single run with mid-run register writes
        do_init();
        do_load();
        start_fresh();
        run_all(-1, 0);
        chk("loaded_kept", stat_loading_done, 1);

        // Rerun re-anneals from the original snapshot, then hits the limit
        do_rerun(ok);
        chk("first_rerun_ok", ok, 1);
        do_rerun(ok);
        chk("second_rerun_err", ok, 0);
        pulse_reset();

        // Three runs with backpressure on the second sample
        do_init();
        do_load();
        run_time_interval = 8'd1;
        total_run_count   = 8'd3;
        total_rerun_count = 8'd0;
        anneal_sch        = {$urandom, $urandom, $urandom, $urandom};
        start_fresh();
        run_all(1, 10);

        // Randomized runs and reruns started from DONE
        for (int s = 0; s < 3; s++) begin
            run_time_interval = 8'($urandom_range(3, 0));
            total_run_count   = 8'($urandom_range(3, 0));
            total_rerun_count = 8'($urandom_range(1, 0));
            anneal_sch        = {$urandom, $urandom, $urandom, $urandom};
            start_fresh();
            run_all(int'($urandom_range(2, 0)), int'($urandom_range(4, 0)));
            for (int i = 0; i <= m_reruns; i++) begin
                do_rerun(ok);
                if (!ok) begin
                    pulse_reset();
                    do_init();
                    do_load();
                end
            end
        end

        // Run before any load
        pulse_reset();
        do_init();
        ctrl_run = 1'b1;
        tick();
        ctrl_run = 1'b0;
        chk("run_unloaded_err", stat_error, 1);
        chk("run_unloaded_anneal_en", anneal_en, 0);

        // Load timeout lands exactly LOAD_TIMEOUT cycles after load_start
        pulse_reset();
        do_init();
        ctrl_load = 1'b1;
        tick();
        ctrl_load = 1'b0;
        chk("tmo_load_start", load_start, 1);
        for (int j = 1; j <= LT; j++) begin
            tick();
            chk("load_timeout", stat_error, (j >= LT) ? 1 : 0);
        end

        // load_done on the timeout cycle wins
        pulse_reset();
        do_init();
        ctrl_load = 1'b1;
        tick();
        ctrl_load = 1'b0;
        tick(LT - 1);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        chk("late_load_done_loaded", stat_loading_done, 1);
        chk("late_load_done_no_err", stat_error, 0);
        tick();
        chk("late_load_done_stays", stat_error, 0);

        // Simultaneous init+load from READY: init taken, load dropped
        ctrl_init = 1'b1;
        ctrl_load = 1'b1;
        tick();
        chk("simul_init_start", init_start, 1);
        chk("simul_load_start", load_start, 0);
        ctrl_init = 1'b0;
        ctrl_load = 1'b0;
        tick();
        chk("simul_load_not_queued", load_start, 0);
        ctrl_run = 1'b1;
        tick();
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        tick(2);
        chk("init_run_dropped_err", stat_error, 0);
        chk("init_run_dropped_anneal", anneal_en, 0);
        chk("simul_loaded_kept", stat_loading_done, 1);
        ctrl_run = 1'b0;
        tick();

        // SAMPLE with the FIFO permanently full
        run_time_interval = 8'd1;
        total_run_count   = 8'd1;
        anneal_sch        = {$urandom, $urandom, $urandom, $urandom};
        start_fresh();
        anneal_phase(0, 1'b1);
        chk("full_req_low", sample_req, 0);
        for (int j = 1; j <= ST + 3; j++) begin
            tick();
            exp_err = WD && (j >= ST);
            chk("watchdog_err", stat_error, exp_err);
            chk("watchdog_sampling", stat_sampling, !exp_err);
        end
        fifo_full = 1'b0;
        pulse_reset();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
